dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (`simple_memory`: combinational read, write at posedge) between two requesters:
  - port 0: pipeline MEM stage.
  - port 1: secondary master (debug loader / DMA).
- Port 0 has fixed priority, with starvation protection for port 1.
- Registers read data and returns it one cycle after the grant, so the memory-stage latency seen by the pipeline is unchanged.
- Deasserted `p0_gnt` is the MEM-stage stall.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive denied port-1 cycles before port 1 is forced; 0 disables forcing.

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 access request.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_gnt  out  1  port 0 granted this cycle (combinational).
- p0_rvalid  out  1  port 0 read data valid (registered).
- p0_rdata  out  DATA_W  port 0 read data (registered).
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- mem_addr  out  ADDR_W  to memory address.
- mem_wdata  out  DATA_W  to memory write data.
- mem_we  out  1  to memory write enable.
- mem_rdata  in  DATA_W  memory combinational read data.

Behaviour:
- Reset (rst_n low, asynchronous): starve_cnt=0; p0/p1_rvalid=0; p0/p1_rdata=0. While rst_n is low, p0_gnt=p1_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0.
- force1 = (STARVE_LIMIT!=0) && (starve_cnt >= STARVE_LIMIT).
- Grant (combinational):
  - p1_gnt = p1_req && (!p0_req || force1).
  - p0_gnt = p0_req && !p1_gnt.
  - At most one grant per cycle; one access per cycle.
- Memory mux:
  - Granted port's addr, wdata and we drive the mem_* outputs.
  - mem_we = granted port's we.
  - No grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Write: completes at the same posedge as the grant. No rvalid is produced.
- Read:
  - At the posedge ending a granted read, pN_rdata <= mem_rdata and pN_rvalid <= 1.
  - pN_rvalid is high for exactly one cycle per granted read.
  - pN_rdata holds its value until the next granted read on that port.
- Back-to-back grants on one port give one rvalid pulse per read, every cycle.
- starve_cnt (width $clog2(STARVE_LIMIT+1), saturating at STARVE_LIMIT):
  - Increments when p1_req && !p1_gnt.
  - Clears when p1_gnt or !p1_req.
- Forced grant lasts exactly one cycle. starve_cnt clears on it, so port 0 regains priority next cycle.
- Requester contract: req/we/addr/wdata stay stable until gnt. The arbiter does not check this.
- Both ports on the same address in one cycle: only one is granted. No forwarding. The loser sees the updated memory on its later grant.
- Reset mid-operation: a pending rvalid is dropped and not delivered after reset release. A write granted in the reset-assert cycle is not performed (mem_we forced 0).

Optional Feature:
- DMEM_ARB_STATS_EN defined:
  - Extra outputs stat_conflicts[31:0] and stat_forced[31:0].
  - stat_conflicts increments each cycle p0_req && p1_req; stat_forced increments each cycle force1 && p1_req && p0_req.
  - Both wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Package riscv_structures.sv gains:
  - typedef dmem_req_s {we, addr, wdata}.
  - typedef dmem_rsp_s {rvalid, rdata}.
  - enum dmem_owner_e {OWN_NONE, OWN_P0, OWN_P1}.
  - localparam DMEM_STARVE_LIMIT_DEFAULT=4.
- One sub-module: dmem_starve_counter, holding the saturating counter and force1 generation, parameterised on STARVE_LIMIT.

Test Plan:
- Reset check: hold rst_n=0 with p0_req=p1_req=1, p0_we=1 -> both gnt=0, mem_we=0, rvalid=0. Release -> p0_gnt=1 next cycle.
- Port 0 priority read: preload mem[0x10]=0xDEADBEEF; p0 read 0x10 -> p0_gnt=1 in cycle N; p0_rvalid=1, p0_rdata=0xDEADBEEF in cycle N+1 only.
- Starvation forcing (STARVE_LIMIT=4): p0_req and p1_req held continuously:
  - p0 granted 4 cycles, p1 granted the 5th, p0 regains the 6th.
  - Pattern repeats every 5 cycles.
- Same-address conflict: p0 writes 0x20=0x11111111 while p1 reads 0x20 -> p0 granted; p1 granted next cycle; p1_rdata=0x11111111.
- Reset mid-read: grant p1 read of 0x30, assert rst_n=0 before the next posedge -> p1_rvalid never pulses; p1_rdata=0.
- With DMEM_ARB_STATS_EN, run the starvation scenario for 10 cycles -> stat_conflicts=10, stat_forced=2.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

   localparam int DMEM_STARVE_LIMIT_DEFAULT = 4;
   localparam int DMEM_ADDR_W = 32;
   localparam int DMEM_DATA_W = 32;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_P0,
      OWN_P1
   } dmem_owner_e;

   typedef struct packed {
      logic                   we;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
   } dmem_req_s;

   typedef struct packed {
      logic                   rvalid;
      logic [DMEM_DATA_W-1:0] rdata;
   } dmem_rsp_s;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Counts consecutive denied port-1 cycles and raises force1 at the limit.
module dmem_starve_counter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic p1_req,
   input  logic p1_gnt,
   output logic force1
);

   // A zero limit would give a zero-width counter, so keep at least one bit.
   localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!p1_req || p1_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt < LIMIT) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign force1 = (STARVE_LIMIT != 0) && (starve_cnt >= LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 fixed priority,
// port 1 forced after STARVE_LIMIT denials. Define DMEM_ARB_STATS_EN for counters.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = DMEM_ADDR_W,
   parameter int DATA_W       = DMEM_DATA_W,
   parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0]       stat_conflicts,
   output logic [31:0]       stat_forced
`endif
);

   logic        force1;
   dmem_owner_e owner;

   dmem_starve_counter #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clk   (clk),
      .rst_n (rst_n),
      .p1_req(p1_req),
      .p1_gnt(p1_gnt),
      .force1(force1)
   );

   // Grants are gated by rst_n so nothing reaches the memory while in reset.
   assign p1_gnt = rst_n && p1_req && (!p0_req || force1);
   assign p0_gnt = rst_n && p0_req && !p1_gnt;

   always_comb begin
      owner = OWN_NONE;
      if (p1_gnt) begin
         owner = OWN_P1;
      end else if (p0_gnt) begin
         owner = OWN_P0;
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (owner)
         OWN_P0: begin
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
         end
         OWN_P1: begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
         end
         default: ;
      endcase
   end

   // Read data is captured at the edge that ends the granted cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_rvalid <= 1'b0;
         p0_rdata  <= '0;
         p1_rvalid <= 1'b0;
         p1_rdata  <= '0;
      end else begin
         p0_rvalid <= (owner == OWN_P0) && !p0_we;
         p1_rvalid <= (owner == OWN_P1) && !p1_we;
         if ((owner == OWN_P0) && !p0_we) begin
            p0_rdata <= mem_rdata;
         end
         if ((owner == OWN_P1) && !p1_we) begin
            p1_rdata <= mem_rdata;
         end
      end
   end

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_conflicts <= '0;
         stat_forced    <= '0;
      end else begin
         if (p0_req && p1_req) begin
            stat_conflicts <= stat_conflicts + 32'd1;
         end
         if (force1 && p1_req && p0_req) begin
            stat_forced <= stat_forced + 32'd1;
         end
      end
   end
`endif

endmodule
